// File: rtl/stopwatch_bcd_counter.sv
// stopwatch_bcd_counter: M:SS.t BCD stopwatch advanced by rising edges of a 10 Hz wave.
// Optional lap hold (freeze displayed digits) enabled by STOPWATCH_LAP_HOLD_EN.
module stopwatch_bcd_counter #(
  parameter int MIN_MAX = 9
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       slow_clk,
  input  logic       start_stop,
  input  logic       clear,
`ifdef STOPWATCH_LAP_HOLD_EN
  input  logic       lap,
  output logic       lap_active,
`endif
  output logic [3:0] tenths,
  output logic [3:0] sec_ones,
  output logic [3:0] sec_tens,
  output logic [3:0] minutes,
  output logic       running,
  output logic       rollover
);
  localparam logic [3:0] MMAX = 4'(MIN_MAX);
  typedef enum logic [1:0] {IDLE, RUN, PAUSE} state_t;
  state_t state_q, state_d;
  logic slow_q, ss_q, clr_q, running_q, rollover_q;
  logic tick, ss_ev, clr_ev, adv, zero, c1, c2, c3, c4;
  logic [3:0] t_q, t_d, so_q, so_d, st_q, st_d, m_q, m_d;
  logic [15:0] live;
  always_comb begin
    tick = slow_clk & ~slow_q;
    ss_ev = start_stop & ~ss_q;
    clr_ev = clear & ~clr_q;
    // clear beats start_stop in PAUSE; clear is ignored in RUN
    state_d = (state_q == PAUSE && clr_ev) ? IDLE :
              ss_ev ? (state_q == RUN ? PAUSE : RUN) : state_q;
    zero = clr_ev && state_q != RUN;
    adv = state_q == RUN && tick;
    c1 = adv && t_q == 4'd9;
    c2 = c1 && so_q == 4'd9;
    c3 = c2 && st_q == 4'd5;
    c4 = c3 && m_q == MMAX;
    t_d = zero ? 4'd0 : adv ? (c1 ? 4'd0 : t_q + 4'd1) : t_q;
    so_d = zero ? 4'd0 : c1 ? (c2 ? 4'd0 : so_q + 4'd1) : so_q;
    st_d = zero ? 4'd0 : c2 ? (c3 ? 4'd0 : st_q + 4'd1) : st_q;
    m_d = zero ? 4'd0 : c3 ? (c4 ? 4'd0 : m_q + 4'd1) : m_q;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      slow_q <= 1'b0;
      ss_q <= 1'b0;
      clr_q <= 1'b0;
      running_q <= 1'b0;
      rollover_q <= 1'b0;
      t_q <= 4'd0;
      so_q <= 4'd0;
      st_q <= 4'd0;
      m_q <= 4'd0;
    end else begin
      state_q <= state_d;
      slow_q <= slow_clk;
      ss_q <= start_stop;
      clr_q <= clear;
      running_q <= state_d == RUN;
      rollover_q <= c4;
      t_q <= t_d;
      so_q <= so_d;
      st_q <= st_d;
      m_q <= m_d;
    end
  end
  assign live = {m_q, st_q, so_q, t_q};
  assign running = running_q;
  assign rollover = rollover_q;
`ifdef STOPWATCH_LAP_HOLD_EN
  logic lap_q, lap_ev, lap_active_q, lap_active_d;
  logic [15:0] hold_q, hold_d;
  always_comb begin
    lap_ev = lap & ~lap_q;
    lap_active_d = lap_active_q ? ~(lap_ev | ss_ev | (state_d == IDLE)) :
                   (lap_ev & ~ss_ev & (state_q == RUN));
    hold_d = (!lap_active_q && lap_active_d) ? live : hold_q;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lap_q <= 1'b0;
      lap_active_q <= 1'b0;
      hold_q <= 16'd0;
    end else begin
      lap_q <= lap;
      lap_active_q <= lap_active_d;
      hold_q <= hold_d;
    end
  end
  assign lap_active = lap_active_q;
  assign {minutes, sec_tens, sec_ones, tenths} = lap_active_q ? hold_q : live;
`else
  assign {minutes, sec_tens, sec_ones, tenths} = live;
`endif
endmodule

// File: tb/tb_stopwatch_bcd_counter.sv
// tb_stopwatch_bcd_counter: directed checks on a MIN_MAX=9 and a MIN_MAX=1 instance sharing inputs.
module tb_stopwatch_bcd_counter;
  logic clk = 0, rst = 1, slow_clk = 0, start_stop = 0, clear = 0;
  logic [3:0] t9, so9, st9, m9, t1, so1, st1, m1;
  logic run9, run1, ro9, ro1;
  logic [15:0] d9, d1;
  int n_vec = 0, n_bad = 0, ro9_cnt = 0, ro1_cnt = 0;
`ifdef STOPWATCH_LAP_HOLD_EN
  logic lap = 0, la9, la1;
`endif
  assign d9 = {m9, st9, so9, t9};
  assign d1 = {m1, st1, so1, t1};
  always #5 clk = ~clk;
  stopwatch_bcd_counter dut9 (
    .clk(clk), .rst(rst), .slow_clk(slow_clk), .start_stop(start_stop), .clear(clear),
`ifdef STOPWATCH_LAP_HOLD_EN
    .lap(lap), .lap_active(la9),
`endif
    .tenths(t9), .sec_ones(so9), .sec_tens(st9), .minutes(m9), .running(run9), .rollover(ro9));
  stopwatch_bcd_counter #(.MIN_MAX(1)) dut1 (
    .clk(clk), .rst(rst), .slow_clk(slow_clk), .start_stop(start_stop), .clear(clear),
`ifdef STOPWATCH_LAP_HOLD_EN
    .lap(lap), .lap_active(la1),
`endif
    .tenths(t1), .sec_ones(so1), .sec_tens(st1), .minutes(m1), .running(run1), .rollover(ro1));
  always @(negedge clk) begin
    ro9_cnt += int'(ro9);
    ro1_cnt += int'(ro1);
  end
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask
  task automatic tick_n(input int n);
    repeat (n) begin
      @(posedge clk); #1 slow_clk = 1;
      repeat (2) @(posedge clk);
      #1 slow_clk = 0;
      repeat (2) @(posedge clk);
    end
    @(negedge clk);
  endtask
  task automatic press(input logic s, input logic c);
    @(posedge clk); #1 start_stop = s; clear = c;
    repeat (3) @(posedge clk);
    #1 start_stop = 0; clear = 0;
    @(negedge clk);
  endtask
  initial begin
    @(negedge clk);
    chk("rst_digits", 32'(d9), 0);
    @(posedge clk); #1 rst = 0;
    @(negedge clk);
    chk("rst_run", 32'(run9), 0);
    chk("rst_ro", 32'(ro9), 0);
    tick_n(25);
    chk("idle_digits", 32'(d9), 0);
    chk("idle_ro", 32'(ro9_cnt), 0);
    @(posedge clk); #1 start_stop = 1;
    @(negedge clk);
    chk("ss_lat_pre", 32'(run9), 0);
    repeat (3) @(negedge clk);
    chk("ss_held_run", 32'(run9), 1);
    #1 start_stop = 0;
    @(posedge clk); #1 slow_clk = 1;
    @(negedge clk);
    chk("tick_lat_pre", 32'(d9), 16'h0000);
    @(negedge clk);
    chk("tick_lat_post", 32'(d9), 16'h0001);
    @(posedge clk); #1 slow_clk = 0;
    repeat (2) @(posedge clk);
    tick_n(124);
    chk("cnt_0125", 32'(d9), 16'h0125);
    chk("cnt_run", 32'(run9), 1);
    tick_n(474);
    chk("cnt_0599", 32'(d1), 16'h0599);
    tick_n(1);
    chk("carry_min", 32'(d1), 16'h1000);
    tick_n(599);
    chk("cnt_1599", 32'(d1), 16'h1599);
    chk("no_ro_yet", 32'(ro1_cnt), 0);
    tick_n(1);
    chk("wrap_mm1", 32'(d1), 16'h0000);
    chk("nowrap_mm9", 32'(d9), 16'h2000);
    chk("ro_pulse_mm1", 32'(ro1_cnt), 1);
    chk("ro_none_mm9", 32'(ro9_cnt), 0);
    press(0, 1);
    chk("clr_in_run", 32'(d9), 16'h2000);
    chk("clr_in_run_st", 32'(run9), 1);
    press(1, 0);
    chk("pause_run", 32'(run9), 0);
    tick_n(10);
    chk("pause_hold", 32'(d9), 16'h2000);
    press(1, 0);
    chk("resume_run", 32'(run9), 1);
    tick_n(874);
    chk("cnt_3274", 32'(d9), 16'h3274);
    chk("cnt_1274", 32'(d1), 16'h1274);
    @(posedge clk); #2 rst = 1;
    #1 slow_clk = 1;
    #1 chk("async_rst_d", 32'(d9), 0);
    chk("async_rst_run", 32'(run9), 0);
    chk("async_rst_d1", 32'(d1), 0);
    @(posedge clk); #1 rst = 0;
    press(1, 0);
    chk("post_rst_run", 32'(run9), 1);
    tick_n(0);
    repeat (3) @(negedge clk);
    chk("slow_high_rel", 32'(d9), 0);
    #1 slow_clk = 0;
    repeat (2) @(posedge clk);
    tick_n(1);
    chk("first_tick", 32'(d9), 16'h0001);
    press(1, 0);
    chk("pause2", 32'(run9), 0);
    press(1, 1);
    chk("both_clr", 32'(d9), 0);
    chk("both_run", 32'(run9), 0);
`ifdef STOPWATCH_LAP_HOLD_EN
    press(1, 0);
    tick_n(42);
    chk("lap_pre", 32'(d9), 16'h0042);
    @(posedge clk); #1 lap = 1;
    repeat (2) @(posedge clk);
    #1 lap = 0;
    @(negedge clk);
    chk("lap_act", 32'(la9), 1);
    tick_n(30);
    chk("lap_frozen", 32'(d9), 16'h0042);
    chk("lap_act_hold", 32'(la1), 1);
    @(posedge clk); #1 lap = 1;
    repeat (2) @(posedge clk);
    #1 lap = 0;
    @(negedge clk);
    chk("lap_release", 32'(d9), 16'h0072);
    chk("lap_inact", 32'(la9), 0);
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule

// File: doc/stopwatch_bcd_counter.md
# stopwatch_bcd_counter

Four-digit BCD stopwatch (M:SS.t) running in the fast `clk` domain and advanced by the 10 Hz square wave produced by the clock divider. It detects rising edges of that slow wave to generate one-cycle count ticks, and a three-state control FSM gates the ticks. The digits feed the seven-segment display driver downstream. No logic is clocked by the slow wave itself.

## Interface
Parameters:
- `MIN_MAX`, default 9, highest minutes value (1..9); count wraps after MIN_MAX:59.9.

Ports:
- `clk`  input  1  system clock (100 MHz board clock).
- `rst`  input  1  asynchronous, active-high reset.
- `slow_clk`  input  1  10 Hz square wave from the clock divider; already a `clk`-domain register output, so no synchroniser is needed.
- `start_stop`  input  1  control level (debounced upstream); the rising edge is the event.
- `clear`  input  1  control level; the rising edge is the event.
- `tenths`  output  4  BCD tenths of a second, 0..9.
- `sec_ones`  output  4  BCD seconds units, 0..9.
- `sec_tens`  output  4  BCD seconds tens, 0..5.
- `minutes`  output  4  BCD minutes, 0..MIN_MAX.
- `running`  output  1  high while in state RUN.
- `rollover`  output  1  one-cycle pulse on wrap from MIN_MAX:59.9 to 0:00.0.

One clock; reset is asynchronous and active-high.

## Operation
- Edge detect:
  - Registers `slow_q`, `ss_q` and `clr_q` delay `slow_clk`, `start_stop` and `clear`.
  - `tick = slow_clk & ~slow_q`, and likewise for `ss_ev` and `clr_ev`.
  - A held level generates exactly one event.
- FSM states are IDLE, RUN and PAUSE. Reset enters IDLE.
- FSM transitions:
  - IDLE, `ss_ev`: go to RUN.
  - RUN, `ss_ev`: go to PAUSE.
  - PAUSE, `ss_ev`: go to RUN.
  - PAUSE, `clr_ev`: go to IDLE and zero all digits.
  - IDLE, `clr_ev`: zero the digits (they are already zero) and stay in IDLE.
  - RUN, `clr_ev`: ignored.
- Simultaneous events:
  - PAUSE with `ss_ev` and `clr_ev` in the same cycle: clear wins, go to IDLE.
  - RUN with both in the same cycle: go to PAUSE, clear ignored.
- Counting:
  - The count advances only when the current (registered) state is RUN and `tick` = 1.
  - A tick in the cycle that leaves RUN is counted.
  - A tick in the cycle that enters RUN from IDLE or PAUSE is not counted.
- Carry chain:
  - `tenths` 9 goes to 0 and carries into `sec_ones`.
  - `sec_ones` 9 goes to 0 and carries into `sec_tens`.
  - `sec_tens` 5 goes to 0 and carries into `minutes`.
  - `minutes` MIN_MAX goes to 0 and asserts `rollover`.
- Digits never hold non-BCD or out-of-range values.

## Timing
- Reset values:
  - All digits 0.
  - `running` = 0 and `rollover` = 0.
  - `slow_q`, `ss_q` and `clr_q` = 0.
  - State is IDLE.
- If `slow_clk` is high at reset release, no tick is produced until its next rising edge.
- Latency:
  - `slow_clk` rises at edge N, so `tick` is high during cycle N.
  - Digits update at edge N+1.
  - `rollover` is high for exactly cycle N+1..N+2.
- Control latency: a `start_stop` rise sampled at edge N causes the state, and `running`, to change at edge N+1.
- Reset asserted mid-count zeroes every register immediately, without waiting for `clk`.
- Tick rate is one per `slow_clk` period (100 ms at 10 Hz). The block makes no assumption about the period beyond at least 2 `clk` cycles high and 2 low.

## Configuration
- `STOPWATCH_LAP_HOLD_EN` defined:
  - Adds input `lap` (1 bit, rising-edge event, reset value of its delay register 0) and output `lap_active` (1 bit, reset 0).
  - A `lap` event in RUN freezes the four digit outputs at their current value and sets `lap_active`.
  - The internal count keeps advancing while frozen; `rollover` still pulses from the internal count.
  - A second `lap` event, a `ss_ev`, or any transition to IDLE releases the freeze. The outputs then show the live count on the next cycle.
  - A `lap` event outside RUN is ignored.
- `STOPWATCH_LAP_HOLD_EN` undefined:
  - No `lap` or `lap_active` ports.
  - Digit outputs always show the live count.

## Test plan
- Reset then 25 `slow_clk` rising edges with `running` = 0 (IDLE): digits stay 0:00.0, `rollover` stays 0.
- `start_stop` pulse, then 125 `slow_clk` rises -> outputs 0:12.5 and `running` = 1; each digit changes exactly one `clk` after its `slow_clk` rise.
- From RUN at 0:59.9 with `MIN_MAX` = 1:
  - One tick -> 1:00.0.
  - Continue to 1:59.9, one more tick -> 0:00.0 with a single-cycle `rollover`.
- RUN -> `start_stop` -> PAUSE:
  - 10 ticks -> digits unchanged.
  - `clear` and `start_stop` rising in the same cycle -> IDLE, 0:00.0, `running` = 0.
  - `clear` in RUN -> ignored.
- `rst` asserted between `clk` edges while at 3:27.4 -> all outputs 0 before the next `clk` edge. `slow_clk` held high across release -> no tick until its next rise.
- With `STOPWATCH_LAP_HOLD_EN`:
  - `lap` at 0:04.2, then 30 ticks -> outputs 0:04.2 and `lap_active` = 1.
  - A second `lap` -> outputs 0:07.2 and `lap_active` = 0.
